// File: rtl/hex_display_bank.sv
// hex_display_bank: multi-digit active-low hex seven-segment driver.
// One shared nibble decoder walks the digits MSD first; blink overlays glyphs.
module hex_display_bank #(
    parameter int DIGITS    = 4,
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  blank_lz,
    input  logic [DIGITS-1:0]     blink_mask,
    output logic                  ready,
    output logic                  done,
    output logic [7*DIGITS-1:0]   hex
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CW = $clog2(BLINK_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(BLINK_DIV - 1);
    localparam logic [IW-1:0] TOP     = IW'(DIGITS - 1);
    localparam logic [6:0]    BLANK   = 7'h7F;

    typedef enum logic {IDLE, DECODE} state_t;

    state_t              state;
    state_t              state_n;
    logic [4*DIGITS-1:0] shadow;
    logic                flag;
    logic                lz_run;
    logic [IW-1:0]       idx;
    logic [6:0]          glyph [DIGITS];
    logic [CW-1:0]       cnt;
    logic                phase;
    logic                accept;
    logic                last;
    logic [3:0]          nib;
    logic                blank;
    logic [6:0]          seg;

    function automatic logic [6:0] decode(input logic [3:0] n);
        case (n)
            4'h0:    decode = 7'h40;
            4'h1:    decode = 7'h79;
            4'h2:    decode = 7'h24;
            4'h3:    decode = 7'h30;
            4'h4:    decode = 7'h19;
            4'h5:    decode = 7'h12;
            4'h6:    decode = 7'h02;
            4'h7:    decode = 7'h78;
            4'h8:    decode = 7'h00;
            4'h9:    decode = 7'h10;
            4'hA:    decode = 7'h08;
            4'hB:    decode = 7'h03;
            4'hC:    decode = 7'h46;
            4'hD:    decode = 7'h21;
            4'hE:    decode = 7'h06;
            default: decode = 7'h0E;
        endcase
    endfunction

    always_comb begin
        nib = 4'h0;
        for (int i = 0; i < DIGITS; i++) begin
            if (IW'(i) == idx) nib = shadow[4*i +: 4];
        end
    end

    // Digit 0 is never blanked so an all-zero value still shows "0".
    assign blank = flag && lz_run && (nib == 4'h0) && (idx != '0);
    assign seg   = blank ? BLANK : decode(nib);

    always_comb begin
        state_n = state;
        ready   = 1'b0;
        accept  = 1'b0;
        last    = 1'b0;
        unique case (state)
            IDLE: begin
                ready = 1'b1;
                if (load) begin
                    accept  = 1'b1;
                    state_n = DECODE;
                end
            end
            DECODE: begin
                if (idx == '0) begin
                    last    = 1'b1;
                    state_n = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_n;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            shadow <= '0;
            flag   <= 1'b0;
            lz_run <= 1'b0;
            idx    <= '0;
            done   <= 1'b0;
        end else begin
            done <= last;
            if (accept) begin
                shadow <= value;
                flag   <= blank_lz;
                lz_run <= 1'b1;
                idx    <= TOP;
            end else if (state == DECODE) begin
                if (nib != 4'h0) lz_run <= 1'b0;
                if (!last)       idx    <= idx - 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DIGITS; i++) glyph[i] <= BLANK;
        end else begin
            for (int i = 0; i < DIGITS; i++) begin
                if (state == DECODE && IW'(i) == idx) glyph[i] <= seg;
            end
        end
    end

    // Blink timebase is free-running and never disturbed by loads.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (cnt == CNT_MAX) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            hex <= '1;
        end else begin
            for (int i = 0; i < DIGITS; i++) begin
                hex[7*i +: 7] <= (blink_mask[i] && phase) ? BLANK : glyph[i];
            end
        end
    end

endmodule

// File: tb/tb_hex_display_bank.sv
// tb_hex_display_bank: directed vectors for a 4-digit bank, blink period 4.
// Inputs driven and outputs sampled on the falling edge.
module tb_hex_display_bank;

    localparam int D = 4;

    logic          clock = 1'b0;
    logic          resetn;
    logic          load = 1'b0;
    logic [15:0]   value = '0;
    logic          blank_lz = 1'b0;
    logic [3:0]    blink_mask = '0;
    logic          ready;
    logic          done;
    logic [27:0]   hex;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;

    hex_display_bank #(.DIGITS(D), .BLINK_DIV(4)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .load       (load),
        .value      (value),
        .blank_lz   (blank_lz),
        .blink_mask (blink_mask),
        .ready      (ready),
        .done       (done),
        .hex        (hex)
    );

    always #5 clock = ~clock;

    always @(negedge clock) if (done === 1'b1) done_cnt++;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [27:0] disp(input logic [6:0] d3, input logic [6:0] d2,
                                         input logic [6:0] d1, input logic [6:0] d0);
        return {d3, d2, d1, d0};
    endfunction

    task automatic do_load(input string tag, input logic [15:0] v, input logic blz,
                           input logic [27:0] mid, input logic [27:0] fin);
        int d0;
        d0 = done_cnt;
        @(negedge clock);
        load = 1'b1; value = v; blank_lz = blz;
        @(negedge clock);
        load = 1'b0;
        check({tag, "_busy"}, 32'(ready), 32'd0);
        for (int j = 1; j <= 5; j++) begin
            @(negedge clock);
            if (j == 2) check({tag, "_mid"}, 32'(hex), 32'(mid));
            if (j == 4) begin
                check({tag, "_done"}, 32'(done), 32'd1);
                check({tag, "_rdy"}, 32'(ready), 32'd1);
            end
        end
        check({tag, "_hex"}, 32'(hex), 32'(fin));
        check({tag, "_ndone"}, 32'(done_cnt - d0), 32'd1);
    endtask

    initial begin
        logic [6:0] d1s [16];
        int nblank;
        int ntrans;
        int d0;

        resetn = 1'b1;
        #12;
        resetn = 1'b0;
        #1;
        check("rst_hex", 32'(hex), 32'h0FFF_FFFF);
        check("rst_rdy", 32'(ready), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        @(negedge clock);
        resetn = 1'b1;
        repeat (3) @(negedge clock);
        check("idle_hex", 32'(hex), 32'h0FFF_FFFF);
        check("idle_rdy", 32'(ready), 32'd1);

        do_load("lz_a5", 16'h00A5, 1'b1,
                disp(7'h7F, 7'h7F, 7'h7F, 7'h7F), disp(7'h7F, 7'h7F, 7'h08, 7'h12));
        do_load("nolz_a5", 16'h00A5, 1'b0,
                disp(7'h40, 7'h7F, 7'h08, 7'h12), disp(7'h40, 7'h40, 7'h08, 7'h12));
        do_load("lz_zero", 16'h0000, 1'b1,
                disp(7'h7F, 7'h40, 7'h08, 7'h12), disp(7'h7F, 7'h7F, 7'h7F, 7'h40));

        // Second load during a decode must be dropped.
        d0 = done_cnt;
        @(negedge clock);
        load = 1'b1; value = 16'hF00E; blank_lz = 1'b0;
        @(negedge clock);
        value = 16'h1234;
        @(negedge clock);
        load = 1'b0;
        repeat (4) @(negedge clock);
        check("ign_hex", 32'(hex), 32'(disp(7'h0E, 7'h40, 7'h40, 7'h06)));
        repeat (6) @(negedge clock);
        check("ign_hex2", 32'(hex), 32'(disp(7'h0E, 7'h40, 7'h40, 7'h06)));
        check("ign_ndone", 32'(done_cnt - d0), 32'd1);

        blink_mask = 4'b0010;
        repeat (2) @(negedge clock);
        for (int j = 0; j < 16; j++) begin
            check("blk_steady", 32'({hex[27:14], hex[6:0]}),
                  32'({7'h0E, 7'h40, 7'h06}));
            d1s[j] = hex[13:7];
            check("blk_d1val", 32'(d1s[j] == 7'h40 || d1s[j] == 7'h7F), 32'd1);
            @(negedge clock);
        end
        nblank = 0;
        ntrans = 0;
        for (int j = 0; j < 16; j++) if (d1s[j] == 7'h7F) nblank++;
        for (int j = 0; j < 15; j++) if (d1s[j] != d1s[j+1]) ntrans++;
        for (int j = 0; j < 12; j++)
            check("blk_toggle", 32'((d1s[j] == 7'h7F) ^ (d1s[j+4] == 7'h7F)), 32'd1);
        check("blk_nblank", 32'(nblank), 32'd8);
        check("blk_ntrans", 32'(ntrans >= 3 && ntrans <= 4), 32'd1);
        blink_mask = 4'b0000;
        repeat (2) @(negedge clock);
        check("blk_off", 32'(hex), 32'(disp(7'h0E, 7'h40, 7'h40, 7'h06)));

        // Reset two cycles into a decode.
        d0 = done_cnt;
        @(negedge clock);
        load = 1'b1; value = 16'h1234; blank_lz = 1'b0;
        @(negedge clock);
        load = 1'b0;
        @(negedge clock);
        resetn = 1'b0;
        #1;
        check("mrst_hex", 32'(hex), 32'h0FFF_FFFF);
        check("mrst_rdy", 32'(ready), 32'd1);
        check("mrst_done", 32'(done), 32'd0);
        @(negedge clock);
        resetn = 1'b1;
        repeat (6) @(negedge clock);
        check("mrst_hex2", 32'(hex), 32'h0FFF_FFFF);
        check("mrst_ndone", 32'(done_cnt - d0), 32'd0);

        do_load("post_rst", 16'h00A5, 1'b1,
                disp(7'h7F, 7'h7F, 7'h7F, 7'h7F), disp(7'h7F, 7'h7F, 7'h08, 7'h12));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
